// File: rtl/avr_alu.sv
// ---------------------------------------------------------------------------
// avr_alu -- 8-bit AVR-style ALU for the CPU execute stage.
//
// Computes the result and the six SREG flags (H, S, V, N, Z, C) for
// ADD/ADC/SUB/SBC/CP/CPC/CPSE/AND/EOR/OR/MOV. Flags an operation does not
// affect pass through from the i_* flag inputs. All outputs are registered,
// so the latency is one cycle.
//
// Optional feature macro: ALU_UNARY_OPS_EN
//   When defined, opcode 0000 is COM and opcode 1100 is NEG. When it is not
//   defined, both opcodes behave like any unmapped opcode (result = op1,
//   flags unchanged).
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      asynchronous active-low reset, clears all outputs
//   i_operation  4-bit operation select
//   i_op1        Rd operand
//   i_op2        Rr operand
//   i_halfcarry, i_sign, i_overflow, i_negative, i_zero, i_carry
//                current SREG H, S, V, N, Z, C
//   o_result     registered result
//   o_halfcarry, o_sign, o_overflow, o_negative, o_zero, o_carry
//                registered new SREG H, S, V, N, Z, C
// ---------------------------------------------------------------------------
module avr_alu (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_operation,
  input  logic [7:0] i_op1,
  input  logic [7:0] i_op2,
  input  logic       i_halfcarry,
  input  logic       i_sign,
  input  logic       i_overflow,
  input  logic       i_negative,
  input  logic       i_zero,
  input  logic       i_carry,
  output logic [7:0] o_result,
  output logic       o_halfcarry,
  output logic       o_sign,
  output logic       o_overflow,
  output logic       o_negative,
  output logic       o_zero,
  output logic       o_carry
);

  localparam logic [3:0] OP_COM  = 4'b0000;
  localparam logic [3:0] OP_CPC  = 4'b0001;
  localparam logic [3:0] OP_SBC  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_CPSE = 4'b0100;
  localparam logic [3:0] OP_CP   = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_ADC  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_EOR  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_MOV  = 4'b1011;
  localparam logic [3:0] OP_NEG  = 4'b1100;

  // Carry-out of one bit position of an adder, recovered from the operand
  // bits and the sum bit (AVR datasheet form).
  function automatic logic add_carry(input logic d, input logic r, input logic res);
    return (d & r) | (r & ~res) | (~res & d);
  endfunction

  // Borrow-out of one bit position of a subtractor.
  function automatic logic sub_borrow(input logic d, input logic r, input logic res);
    return (~d & r) | (r & res) | (res & ~d);
  endfunction

  logic [7:0] result_next;
  logic       h_next, s_next, v_next, n_next, z_next, c_next;
  logic       carry_in;

  always_comb begin
    result_next = i_op1;
    h_next      = i_halfcarry;
    s_next      = i_sign;
    v_next      = i_overflow;
    n_next      = i_negative;
    z_next      = i_zero;
    c_next      = i_carry;
    carry_in    = 1'b0;

    case (i_operation)
      OP_ADD, OP_ADC: begin
        carry_in    = (i_operation == OP_ADC) & i_carry;
        result_next = i_op1 + i_op2 + {7'b0, carry_in};
        h_next      = add_carry(i_op1[3], i_op2[3], result_next[3]);
        c_next      = add_carry(i_op1[7], i_op2[7], result_next[7]);
        v_next      = (i_op1[7] & i_op2[7] & ~result_next[7]) |
                      (~i_op1[7] & ~i_op2[7] & result_next[7]);
        n_next      = result_next[7];
        s_next      = result_next[7] ^ v_next;
        z_next      = (result_next == 8'h00);
      end

      OP_SUB, OP_CP, OP_SBC, OP_CPC: begin
        carry_in    = ((i_operation == OP_SBC) | (i_operation == OP_CPC)) & i_carry;
        result_next = i_op1 - i_op2 - {7'b0, carry_in};
        h_next      = sub_borrow(i_op1[3], i_op2[3], result_next[3]);
        c_next      = sub_borrow(i_op1[7], i_op2[7], result_next[7]);
        v_next      = (i_op1[7] & ~i_op2[7] & ~result_next[7]) |
                      (~i_op1[7] & i_op2[7] & result_next[7]);
        n_next      = result_next[7];
        s_next      = result_next[7] ^ v_next;
        // With-borrow forms keep Z cleared once any earlier byte of a
        // multi-byte subtract/compare was non-zero.
        if ((i_operation == OP_SBC) || (i_operation == OP_CPC))
          z_next = (result_next == 8'h00) & i_zero;
        else
          z_next = (result_next == 8'h00);
      end

      OP_AND, OP_EOR, OP_OR: begin
        if (i_operation == OP_AND)
          result_next = i_op1 & i_op2;
        else if (i_operation == OP_EOR)
          result_next = i_op1 ^ i_op2;
        else
          result_next = i_op1 | i_op2;
        v_next = 1'b0;
        n_next = result_next[7];
        s_next = result_next[7];
        z_next = (result_next == 8'h00);
      end

      OP_MOV: begin
        result_next = i_op2;
      end

      // Skip decision happens outside; only the pass-through is needed here.
      OP_CPSE: begin
        result_next = i_op1;
      end

`ifdef ALU_UNARY_OPS_EN
      OP_COM: begin
        result_next = ~i_op1;
        c_next      = 1'b1;
        v_next      = 1'b0;
        n_next      = result_next[7];
        s_next      = result_next[7];
        z_next      = (result_next == 8'h00);
      end

      OP_NEG: begin
        result_next = 8'h00 - i_op1;
        h_next      = result_next[3] | i_op1[3];
        c_next      = (result_next != 8'h00);
        v_next      = (result_next == 8'h80);
        n_next      = result_next[7];
        s_next      = result_next[7] ^ (result_next == 8'h80);
        z_next      = (result_next == 8'h00);
      end
`endif

      default: begin
        result_next = i_op1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_result    <= 8'h00;
      o_halfcarry <= 1'b0;
      o_sign      <= 1'b0;
      o_overflow  <= 1'b0;
      o_negative  <= 1'b0;
      o_zero      <= 1'b0;
      o_carry     <= 1'b0;
    end else begin
      o_result    <= result_next;
      o_halfcarry <= h_next;
      o_sign      <= s_next;
      o_overflow  <= v_next;
      o_negative  <= n_next;
      o_zero      <= z_next;
      o_carry     <= c_next;
    end
  end

endmodule

// File: tb/tb_avr_alu.sv
// ---------------------------------------------------------------------------
// tb_avr_alu -- self-checking bench for avr_alu.
// Flags are handled as a 6-bit vector ordered {H, S, V, N, Z, C}.
// ---------------------------------------------------------------------------
module tb_avr_alu;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [3:0] i_operation;
  logic [7:0] i_op1, i_op2;
  logic       i_halfcarry, i_sign, i_overflow, i_negative, i_zero, i_carry;
  logic [7:0] o_result;
  logic       o_halfcarry, o_sign, o_overflow, o_negative, o_zero, o_carry;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  logic [7:0] exp_res;
  logic [5:0] exp_flags;

  avr_alu dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_operation (i_operation),
    .i_op1       (i_op1),
    .i_op2       (i_op2),
    .i_halfcarry (i_halfcarry),
    .i_sign      (i_sign),
    .i_overflow  (i_overflow),
    .i_negative  (i_negative),
    .i_zero      (i_zero),
    .i_carry     (i_carry),
    .o_result    (o_result),
    .o_halfcarry (o_halfcarry),
    .o_sign      (o_sign),
    .o_overflow  (o_overflow),
    .o_negative  (o_negative),
    .o_zero      (o_zero),
    .o_carry     (o_carry)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [5:0] out_flags();
    return {o_halfcarry, o_sign, o_overflow, o_negative, o_zero, o_carry};
  endfunction

  // Reference model in plain integer arithmetic: carries/borrows come from
  // range checks on the true sum/difference, overflow from the signed range.
  function automatic logic [13:0] alu_model(input logic [3:0] op, input logic [7:0] d8,
                                            input logic [7:0] r8, input logic [5:0] fin);
    int ud, ur, sd, sr, ci, full, sfull;
    logic [7:0] res;
    logic h, s, v, n, z, c;
    ud = int'(d8);
    ur = int'(r8);
    sd = (ud > 127) ? ud - 256 : ud;
    sr = (ur > 127) ? ur - 256 : ur;
    {h, s, v, n, z, c} = fin;
    res = d8;
    case (op)
      4'h3, 4'h7: begin
        ci    = (op == 4'h7) ? int'(fin[0]) : 0;
        full  = ud + ur + ci;
        sfull = sd + sr + ci;
        res   = 8'(full);
        c     = (full > 255);
        h     = ((ud % 16) + (ur % 16) + ci) > 15;
        v     = (sfull > 127) || (sfull < -128);
        n     = res[7];
        s     = n ^ v;
        z     = (res == 0);
      end
      4'h6, 4'h5, 4'h2, 4'h1: begin
        ci    = (op == 4'h2 || op == 4'h1) ? int'(fin[0]) : 0;
        full  = ud - ur - ci;
        sfull = sd - sr - ci;
        res   = 8'(full + 256);
        c     = (full < 0);
        h     = (ud % 16) < ((ur % 16) + ci);
        v     = (sfull > 127) || (sfull < -128);
        n     = res[7];
        s     = n ^ v;
        z     = (res == 0) && ((ci == 0 && (op == 4'h6 || op == 4'h5)) ? 1'b1 :
                               (op == 4'h6 || op == 4'h5) ? 1'b1 : fin[1]);
      end
      4'h8, 4'h9, 4'hA: begin
        res = (op == 4'h8) ? (d8 & r8) : (op == 4'h9) ? (d8 ^ r8) : (d8 | r8);
        v = 1'b0; n = res[7]; s = res[7]; z = (res == 0);
      end
      4'hB: res = r8;
`ifdef ALU_UNARY_OPS_EN
      4'h0: begin
        res = 8'(255 - ud);
        c = 1'b1; v = 1'b0; n = res[7]; s = n; z = (res == 0);
      end
      4'hC: begin
        res = 8'((256 - ud) % 256);
        h = res[3] | d8[3]; c = (res != 0); v = (res == 8'h80);
        n = res[7]; s = n ^ v; z = (res == 0);
      end
`endif
      default: res = d8;
    endcase
    return {res, h, s, v, n, z, c};
  endfunction

  // Scoreboard: expected outputs follow the same register timing as the DUT.
  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)
      {exp_res, exp_flags} <= 14'h0;
    else
      {exp_res, exp_flags} <= alu_model(i_operation, i_op1, i_op2,
        {i_halfcarry, i_sign, i_overflow, i_negative, i_zero, i_carry});
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      checks++;
      if (o_result !== exp_res || out_flags() !== exp_flags) begin
        errors++;
        $display("FAIL scoreboard t=%0t op=%h: got R=%h F=%b, expected R=%h F=%b",
                 $time, i_operation, o_result, out_flags(), exp_res, exp_flags);
      end
    end
  end

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] d;
    logic [7:0] r;
    logic [5:0] fin;
    logic [7:0] er;
    logic [5:0] ef;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string nm, input logic [3:0] op, input logic [7:0] d,
                         input logic [7:0] r, input logic [5:0] fin,
                         input logic [7:0] er, input logic [5:0] ef);
    vec_t v;
    v.name = nm; v.op = op; v.d = d; v.r = r; v.fin = fin; v.er = er; v.ef = ef;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] d, input logic [7:0] r,
                       input logic [5:0] fin);
    i_operation = op;
    i_op1 = d;
    i_op2 = r;
    {i_halfcarry, i_sign, i_overflow, i_negative, i_zero, i_carry} = fin;
  endtask

  task automatic check_lit(input string nm, input logic [7:0] er, input logic [5:0] ef);
    checks++;
    if (o_result !== er || out_flags() !== ef) begin
      errors++;
      $display("FAIL %s: got R=%h F=%b, expected R=%h F=%b", nm, o_result, out_flags(), er, ef);
    end else begin
      $display("ok   %s: R=%h F=%b", nm, o_result, out_flags());
    end
  endtask

  initial begin
    //        name        op    d      r      fin        R      {H,S,V,N,Z,C}
    add_vec("add_0f_01",  4'h3, 8'h0F, 8'h01, 6'b000000, 8'h10, 6'b100000);
    add_vec("add_80_80",  4'h3, 8'h80, 8'h80, 6'b000000, 8'h00, 6'b011011);
    add_vec("adc_7f_c1",  4'h7, 8'h7F, 8'h00, 6'b000001, 8'h80, 6'b101100);
    add_vec("adc_ff_c1",  4'h7, 8'hFF, 8'h00, 6'b000001, 8'h00, 6'b100011);
    add_vec("sub_00_01",  4'h6, 8'h00, 8'h01, 6'b000000, 8'hFF, 6'b110101);
    add_vec("sbc_10_c1",  4'h2, 8'h10, 8'h00, 6'b000001, 8'h0F, 6'b100000);
    add_vec("cpc_z0",     4'h1, 8'h01, 8'h00, 6'b000001, 8'h00, 6'b000000);
    add_vec("cpc_z1",     4'h1, 8'h01, 8'h00, 6'b000011, 8'h00, 6'b000010);
    add_vec("cp_80_01",   4'h5, 8'h80, 8'h01, 6'b000000, 8'h7F, 6'b111000);
    add_vec("cp_eq",      4'h5, 8'h05, 8'h05, 6'b000000, 8'h00, 6'b000010);
    add_vec("and_80_ff",  4'h8, 8'h80, 8'hFF, 6'b101001, 8'h80, 6'b110101);
    add_vec("eor_5a_5a",  4'h9, 8'h5A, 8'h5A, 6'b000000, 8'h00, 6'b000010);
    add_vec("or_80_01",   4'hA, 8'h80, 8'h01, 6'b001000, 8'h81, 6'b010100);
    add_vec("mov_a5",     4'hB, 8'h33, 8'hA5, 6'b101010, 8'hA5, 6'b101010);
    add_vec("cpse_pass",  4'h4, 8'h12, 8'h34, 6'b101010, 8'h12, 6'b101010);
    add_vec("unmapped_f", 4'hF, 8'h9C, 8'h11, 6'b110011, 8'h9C, 6'b110011);
`ifdef ALU_UNARY_OPS_EN
    add_vec("com_55",     4'h0, 8'h55, 8'h00, 6'b100000, 8'hAA, 6'b110101);
    add_vec("neg_01",     4'hC, 8'h01, 8'h00, 6'b000000, 8'hFF, 6'b110101);
`else
    add_vec("op0_unmap",  4'h0, 8'h55, 8'h00, 6'b100000, 8'h55, 6'b100000);
    add_vec("opc_unmap",  4'hC, 8'h01, 8'h00, 6'b000000, 8'h01, 6'b000000);
`endif

    drive(4'h3, 8'h00, 8'h00, 6'b000000);
    i_reset = 1'b1;
    #2 i_reset = 1'b0;
    #1 check_lit("reset_state", 8'h00, 6'b000000);
    chk_en = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1 check_lit("post_release_hold", 8'h00, 6'b000000);

    // Directed vectors: drive on falling edge, check 1 ns after the rising edge.
    foreach (vecs[k]) begin
      @(negedge i_clk);
      drive(vecs[k].op, vecs[k].d, vecs[k].r, vecs[k].fin);
      @(posedge i_clk);
      #1 check_lit(vecs[k].name, vecs[k].er, vecs[k].ef);
    end

    // Broad sweep checked only by the scoreboard.
    for (int k = 0; k < 300; k++) begin
      @(negedge i_clk);
      drive(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 6'($urandom));
    end

    // Asynchronous reset in the middle of a cycle with a non-zero result in flight.
    @(negedge i_clk);
    drive(4'hB, 8'h00, 8'hC3, 6'b111111);
    @(posedge i_clk);
    #1 check_lit("before_async_reset", 8'hC3, 6'b111111);
    #2 i_reset = 1'b0;
    #1 check_lit("async_reset_midcycle", 8'h00, 6'b000000);
    @(posedge i_clk);
    #1 check_lit("reset_held_over_edge", 8'h00, 6'b000000);
    @(negedge i_clk);
    i_reset = 1'b1;
    drive(4'h3, 8'h0F, 8'h01, 6'b000000);
    @(posedge i_clk);
    #1 check_lit("add_after_reset", 8'h10, 6'b100000);

    @(negedge i_clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avr_alu.md
Name: avr_alu

Overview:
- 8-bit AVR-style arithmetic/logic unit used in the CPU execute stage.
- Computes a result and the six SREG flags (H, S, V, N, Z, C) for ADD/ADC/SUB/SBC/CP/CPC/CPSE/AND/EOR/OR/MOV.
- Flag inputs are the current SREG bits; flags an operation does not affect pass through unchanged.
- Outputs are registered: one-cycle latency.

Parameters:
- None; the datapath is fixed at 8 bits.

Ports:
- i_clk  input  1  rising-edge clock
- i_reset  input  1  asynchronous, active-low reset
- i_operation  input  4  operation select
- i_op1  input  8  Rd operand
- i_op2  input  8  Rr operand
- o_result  output  8  registered result
- i_halfcarry, i_sign, i_overflow, i_negative, i_zero, i_carry  input  1 each  current SREG H, S, V, N, Z, C
- o_halfcarry, o_sign, o_overflow, o_negative, o_zero, o_carry  output  1 each  registered new H, S, V, N, Z, C

Behaviour:
- Reset: i_reset=0 asynchronously clears o_result and all six flag outputs to 0. Outputs hold 0 until the first rising edge after release.
- Each rising edge with i_reset=1 samples all inputs and registers the result and flags. Latency is 1 cycle; there is no handshake.
- Opcode map:
  - 0001 CPC
  - 0010 SBC
  - 0011 ADD
  - 0100 CPSE
  - 0101 CP
  - 0110 SUB
  - 0111 ADC
  - 1000 AND
  - 1001 EOR
  - 1010 OR
  - 1011 MOV
  - Any other opcode: result=op1, all flags unchanged.
- Notation: d=op1, r=op2, R=result, Cin=i_carry, Zin=i_zero.
- ADD: R=d+r. ADC: R=d+r+Cin.
  - H = d3&r3 | r3&~R3 | ~R3&d3
  - C = same expression on bit 7
  - V = d7&r7&~R7 | ~d7&~r7&R7
- SUB/CP: R=d-r. SBC/CPC: R=d-r-Cin (mod 256).
  - H = ~d3&r3 | r3&R3 | R3&~d3
  - C = same expression on bit 7
  - V = d7&~r7&~R7 | ~d7&r7&R7
- Arithmetic ops: N=R7, S=N^V.
- Z: ADD/ADC/SUB/CP give Z=(R==0). SBC/CPC give Z=(R==0)&Zin, so Z is sticky-clear across a multi-byte compare.
- CP/CPC still drive o_result with the difference; consumers ignore it.
- AND/EOR/OR:
  - R = d&r, d^r, d|r respectively.
  - V=0, N=R7, S=R7, Z=(R==0).
  - H and C unchanged.
- MOV: R=r; all flags unchanged.
- CPSE: R=op1; all flags unchanged. Equality for the skip is resolved outside this block.
- "Unchanged" means o_x equals the i_x value sampled at the same edge.
- Carry and borrow are computed at 9-bit width. Results wrap modulo 256.
- Reset asserted mid-operation discards the in-flight result.

Optional Feature:
- Macro ALU_UNARY_OPS_EN.
- When defined:
  - Opcode 0000 = COM: R=~d, C=1, V=0, N=R7, S=N, Z=(R==0), H unchanged.
  - Opcode 1100 = NEG: R=0-d, H=R3|d3, C=(R!=0), V=(R==0x80), N=R7, S=N^V, Z=(R==0).
- When undefined: opcodes 0000 and 1100 behave like any unmapped opcode (result=op1, flags unchanged).

Test Plan:
- ADD 0x0F+0x01, all flag inputs 0 -> R=0x10, H=1, S=V=N=Z=C=0.
- ADD 0x80+0x80 -> R=0x00, C=1, V=1, Z=1, N=0, S=1, H=0. ADC 0x7F+0x00 with Cin=1 -> R=0x80, H=1, V=1, N=1, S=0, C=0, Z=0.
- SUB 0x00-0x01 -> R=0xFF, C=1, H=1, N=1, V=0, S=1, Z=0. SBC 0x10-0x00 with Cin=1 -> R=0x0F, H=1, C=0.
- CPC 0x01 vs 0x00 with Cin=1, Zin=0 -> Z=0, C=0, H=0; same operands with Zin=1 -> Z=1.
- AND 0x80&0xFF with Hin=1, Cin=1, Vin=1 -> R=0x80, N=1, S=1, V=0, Z=0, H=1, C=1. EOR 0x5A^0x5A -> R=0, Z=1.
- MOV op2=0xA5 with flag inputs 0b101010 (H..C) -> R=0xA5, flags 0b101010. CPSE flags pass through likewise. i_reset=0 at any time -> all outputs 0 immediately, without waiting for a clock edge.
